// File: rtl/clock_alarm_core.sv
// Timekeeping core: CLK_HZ divider to a 1 Hz enable, 24-hour HH:MM:SS counter with load, one-shot alarm ringer.
// Latency: time/alarm loads land on the next edge; AlarmLED rises one edge after time equals the alarm time.
// No backpressure: level enables are sampled every cycle; out-of-range set values drop the whole load.
module clock_alarm_core #(
  parameter int CLK_HZ    = 50000000,
  parameter int ALARM_LEN = 30
) (
  input  logic       CLK_50,
  input  logic       reset_en,
  input  logic       run_en,
  input  logic       set_time_en,
  input  logic       set_alarm_en,
  input  logic [5:0] hour_set,
  input  logic [5:0] minute_set,
  input  logic [5:0] second_set,
  output logic       clock_clk,
  output logic       sec_tick,
  output logic [5:0] hour,
  output logic [5:0] minute,
  output logic [5:0] second,
  output logic       alarm_armed,
  output logic       AlarmLED,
  output logic [3:0] LEDR
);

  localparam int CW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [5:0]    al_hour_q, al_hour_d, al_min_q, al_min_d, al_sec_q, al_sec_d;
  logic          armed_q, armed_d;
  logic          match_q;
  logic [5:0]    ring_q, ring_d;
  logic          led_q, led_d;
  logic [3:0]    leds_q, leds_d;

  logic set_ok;
  logic match;

  // Set values are only usable when every field is in its legal range.
  assign set_ok = (hour_set <= 6'd23) && (minute_set <= 6'd59) && (second_set <= 6'd59);

  assign sec_tick  = run_en && (cnt_q == CW'(CLK_HZ - 1));
  assign clock_clk = (cnt_q < CW'(CLK_HZ / 2));
  assign match     = armed_q && ({hour_q, min_q, sec_q} == {al_hour_q, al_min_q, al_sec_q});

  // Divider and time counter next state: load beats tick, tick beats hold.
  always_comb begin
    cnt_d  = cnt_q;
    hour_d = hour_q;
    min_d  = min_q;
    sec_d  = sec_q;
    if (run_en) begin
      cnt_d = (cnt_q == CW'(CLK_HZ - 1)) ? '0 : cnt_q + 1'b1;
    end
    if (set_time_en) begin
      if (set_ok) begin
        hour_d = hour_set;
        min_d  = minute_set;
        sec_d  = second_set;
      end
    end else if (sec_tick) begin
      if (sec_q == 6'd59) begin
        sec_d = '0;
        if (min_q == 6'd59) begin
          min_d  = '0;
          hour_d = (hour_q == 6'd23) ? '0 : hour_q + 1'b1;
        end else begin
          min_d = min_q + 1'b1;
        end
      end else begin
        sec_d = sec_q + 1'b1;
      end
    end
  end

  // Alarm next state: arming/silencing first, then ring start on a fresh match, then per-second countdown.
  always_comb begin
    al_hour_d = al_hour_q;
    al_min_d  = al_min_q;
    al_sec_d  = al_sec_q;
    armed_d   = armed_q;
    ring_d    = ring_q;
    led_d     = led_q;
    leds_d    = leds_q;
    if (set_alarm_en) begin
      if (set_ok) begin
        al_hour_d = hour_set;
        al_min_d  = minute_set;
        al_sec_d  = second_set;
        armed_d   = 1'b1;
      end
      ring_d = '0;
      led_d  = 1'b0;
      leds_d = '0;
    end else if (match && !match_q) begin
      ring_d = 6'(ALARM_LEN);
      led_d  = 1'b1;
      leds_d = 4'b0001;
    end else if (led_q && sec_tick) begin
      if (ring_q <= 6'd1) begin
        ring_d = '0;
        led_d  = 1'b0;
        leds_d = '0;
      end else begin
        ring_d = ring_q - 1'b1;
        leds_d = {leds_q[2:0], leds_q[3]};
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge CLK_50 or negedge reset_en) begin
    if (!reset_en) begin
      cnt_q     <= '0;
      hour_q    <= '0;
      min_q     <= '0;
      sec_q     <= '0;
      al_hour_q <= '0;
      al_min_q  <= '0;
      al_sec_q  <= '0;
      armed_q   <= 1'b0;
      match_q   <= 1'b0;
      ring_q    <= '0;
      led_q     <= 1'b0;
      leds_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      hour_q    <= hour_d;
      min_q     <= min_d;
      sec_q     <= sec_d;
      al_hour_q <= al_hour_d;
      al_min_q  <= al_min_d;
      al_sec_q  <= al_sec_d;
      armed_q   <= armed_d;
      match_q   <= match;
      ring_q    <= ring_d;
      led_q     <= led_d;
      leds_q    <= leds_d;
    end
  end

  assign hour        = hour_q;
  assign minute      = min_q;
  assign second      = sec_q;
  assign alarm_armed = armed_q;
  assign AlarmLED    = led_q;
  assign LEDR        = leds_q;

endmodule

// File: tb/tb_clock_alarm_core.sv
// Directed bench for clock_alarm_core with CLK_HZ=4 and ALARM_LEN=3.
module tb_clock_alarm_core;

  logic       clk = 1'b0;
  logic       reset_en, run_en, set_time_en, set_alarm_en;
  logic [5:0] hour_set, minute_set, second_set;
  logic       clock_clk, sec_tick, alarm_armed, AlarmLED;
  logic [5:0] hour, minute, second;
  logic [3:0] LEDR;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  clock_alarm_core #(.CLK_HZ(4), .ALARM_LEN(3)) dut (
    .CLK_50(clk), .reset_en(reset_en), .run_en(run_en),
    .set_time_en(set_time_en), .set_alarm_en(set_alarm_en),
    .hour_set(hour_set), .minute_set(minute_set), .second_set(second_set),
    .clock_clk(clock_clk), .sec_tick(sec_tick),
    .hour(hour), .minute(minute), .second(second),
    .alarm_armed(alarm_armed), .AlarmLED(AlarmLED), .LEDR(LEDR)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input string tag, input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    chk(tag, {14'd0, hour, minute, second}, {14'd0, h, m, s});
  endtask

  // One clock edge, then settle 1 time unit before looking at outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance until the edge that consumes the next sec_tick has passed.
  task automatic next_sec();
    int n = 0;
    while (sec_tick !== 1'b1 && n < 16) begin
      step();
      n++;
    end
    chk("tick_timeout", {31'd0, n < 16}, 32'd1);
    step();
  endtask

  task automatic load_time(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    hour_set = h; minute_set = m; second_set = s;
    set_time_en = 1'b1;
    step();
    set_time_en = 1'b0;
  endtask

  task automatic load_alarm(input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
    hour_set = h; minute_set = m; second_set = s;
    set_alarm_en = 1'b1;
    step();
    set_alarm_en = 1'b0;
  endtask

  initial begin
    reset_en = 1'b0; run_en = 1'b0; set_time_en = 1'b0; set_alarm_en = 1'b0;
    hour_set = '0; minute_set = '0; second_set = '0;
    #1;
    chk_time("rst_time", 6'd0, 6'd0, 6'd0);
    chk("rst_clock_clk", {31'd0, clock_clk}, 32'd1);
    chk("rst_sec_tick", {31'd0, sec_tick}, 32'd0);
    chk("rst_armed", {31'd0, alarm_armed}, 32'd0);
    chk("rst_led", {31'd0, AlarmLED}, 32'd0);
    chk("rst_ledr", {28'd0, LEDR}, 32'd0);

    // Release reset and run: cnt 0,1,2,3 gives clock_clk 1,1,0,0 and a tick at cnt 3.
    step(); step();
    reset_en = 1'b1; run_en = 1'b1;
    chk("run_c0_clk", {31'd0, clock_clk}, 32'd1);
    step();
    chk("run_c1_clk", {31'd0, clock_clk}, 32'd1);
    chk("run_c1_tick", {31'd0, sec_tick}, 32'd0);
    step();
    chk("run_c2_clk", {31'd0, clock_clk}, 32'd0);
    step();
    chk("run_c3_clk", {31'd0, clock_clk}, 32'd0);
    chk("run_c3_tick", {31'd0, sec_tick}, 32'd1);
    chk("run_c3_sec", {26'd0, second}, 32'd0);
    step();
    chk("run_wrap_sec", {26'd0, second}, 32'd1);
    chk("run_wrap_tick", {31'd0, sec_tick}, 32'd0);
    chk("run_wrap_clk", {31'd0, clock_clk}, 32'd1);

    // Freeze at cnt=2.
    step(); step();
    run_en = 1'b0;
    repeat (6) step();
    chk("frz_clk", {31'd0, clock_clk}, 32'd0);
    chk("frz_tick", {31'd0, sec_tick}, 32'd0);
    chk("frz_sec", {26'd0, second}, 32'd1);
    run_en = 1'b1;
    step();
    chk("thaw_tick", {31'd0, sec_tick}, 32'd1);
    step();
    chk("thaw_sec", {26'd0, second}, 32'd2);

    // Rollovers.
    load_time(6'd23, 6'd59, 6'd58);
    chk_time("load_235958", 6'd23, 6'd59, 6'd58);
    next_sec();
    chk_time("roll_235959", 6'd23, 6'd59, 6'd59);
    next_sec();
    chk_time("roll_000000", 6'd0, 6'd0, 6'd0);
    load_time(6'd0, 6'd0, 6'd59);
    next_sec();
    chk_time("roll_000100", 6'd0, 6'd1, 6'd0);
    load_time(6'd0, 6'd59, 6'd59);
    next_sec();
    chk_time("roll_010000", 6'd1, 6'd0, 6'd0);

    // Invalid loads (cnt is 0 here, so no tick on the load edge).
    load_time(6'd24, 6'd0, 6'd0);
    chk_time("bad_hour_hold", 6'd1, 6'd0, 6'd0);
    load_alarm(6'd0, 6'd60, 6'd0);
    chk("bad_min_unarmed", {31'd0, alarm_armed}, 32'd0);

    // Alarm at 00:00:05 with a 3-second ring.
    load_alarm(6'd0, 6'd0, 6'd5);
    chk("arm", {31'd0, alarm_armed}, 32'd1);
    load_time(6'd0, 6'd0, 6'd0);
    repeat (5) next_sec();
    chk_time("at_alarm", 6'd0, 6'd0, 6'd5);
    chk("led_not_yet", {31'd0, AlarmLED}, 32'd0);
    step();
    chk("ring_start_led", {31'd0, AlarmLED}, 32'd1);
    chk("ring_start_ledr", {28'd0, LEDR}, 32'h1);
    next_sec();
    chk("ring_t1_ledr", {28'd0, LEDR}, 32'h2);
    next_sec();
    chk("ring_t2_ledr", {28'd0, LEDR}, 32'h4);
    chk("ring_t2_led", {31'd0, AlarmLED}, 32'd1);
    next_sec();
    chk("ring_end_led", {31'd0, AlarmLED}, 32'd0);
    chk("ring_end_ledr", {28'd0, LEDR}, 32'h0);
    chk("still_armed", {31'd0, alarm_armed}, 32'd1);

    // Loading time onto the alarm time fires it; set_alarm_en silences and rearms.
    load_time(6'd0, 6'd0, 6'd5);
    step();
    chk("load_fire_led", {31'd0, AlarmLED}, 32'd1);
    load_alarm(6'd12, 6'd34, 6'd56);
    chk("silence_led", {31'd0, AlarmLED}, 32'd0);
    chk("silence_ledr", {28'd0, LEDR}, 32'h0);
    chk("silence_armed", {31'd0, alarm_armed}, 32'd1);
    load_time(6'd12, 6'd34, 6'd56);
    step();
    chk("new_alarm_led", {31'd0, AlarmLED}, 32'd1);
    chk("new_alarm_ledr", {28'd0, LEDR}, 32'h1);

    // Asynchronous reset between edges while ringing.
    #2;
    reset_en = 1'b0;
    #1;
    chk("arst_led", {31'd0, AlarmLED}, 32'd0);
    chk("arst_ledr", {28'd0, LEDR}, 32'h0);
    chk("arst_armed", {31'd0, alarm_armed}, 32'd0);
    chk_time("arst_time", 6'd0, 6'd0, 6'd0);
    chk("arst_clk", {31'd0, clock_clk}, 32'd1);
    chk("arst_tick", {31'd0, sec_tick}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
